// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and the baud divisor helper for the 8N1 UART.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int MID_SAMPLE = 8;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam int BIT_W      = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // RX_WAIT holds off re-arming after a framing error until the line is high again.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    function automatic int calc_div(input int freq_hz, input int baud);
        int d;
        d = freq_hz / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clk tick every DIV clocks, shared by RX and TX.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    // restart re-phases the divider on a TX start so the TX frame is an exact multiple of DIV.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with 16x oversampling; byte-wide handshake toward the core.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int freq_hz = 100000000,
    parameter int baud    = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_busy
);

    localparam int                DIV       = calc_div(freq_hz, baud);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(MID_SAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic tick;
    logic tx_start;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (tx_start),
        .tick    (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t             tx_state, tx_state_d;
    logic [TICK_W-1:0]     tx_cnt, tx_cnt_d;
    logic [BIT_W-1:0]      tx_bit, tx_bit_d;
    logic [DATA_BITS-1:0]  tx_shift, tx_shift_d;
    logic                  txd_d;

    assign tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            uart_txd <= txd_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        txd_d      = 1'b1;
        tx_start   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_wr) begin
                    tx_shift_d = tx_data;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_start   = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                txd_d = 1'b0;
                if (tick) begin
                    tx_cnt_d = tx_cnt + 1'b1;
                    if (tx_cnt == TICK_LAST) tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                txd_d = tx_shift[0];
                if (tick) begin
                    tx_cnt_d = tx_cnt + 1'b1;
                    if (tx_cnt == TICK_LAST) begin
                        tx_shift_d = tx_shift >> 1;
                        tx_bit_d   = tx_bit + 1'b1;
                        if (tx_bit == BIT_LAST) tx_state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    tx_cnt_d = tx_cnt + 1'b1;
                    if (tx_cnt == TICK_LAST) tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    logic                  rxd_meta, rxd_sync;
    rx_state_t             rx_state, rx_state_d;
    logic [TICK_W-1:0]     rx_cnt, rx_cnt_d;
    logic [BIT_W-1:0]      rx_bit, rx_bit_d;
    logic [DATA_BITS-1:0]  rx_shift, rx_shift_d;
    logic                  rx_done, rx_ferr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_avail <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            // A completing byte outranks a simultaneous acknowledge.
            if (rx_done) begin
                rx_data  <= rx_shift;
                rx_avail <= 1'b1;
            end else if (rx_ack) begin
                rx_avail <= 1'b0;
            end
            if (rx_ferr) rx_error <= 1'b1;
            else if (rx_ack) rx_error <= 1'b0;
        end
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxd_sync) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt + 1'b1;
                    if (rx_cnt == TICK_MID) begin
                        if (rxd_sync) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_cnt_d   = '0;
                            rx_bit_d   = '0;
                            rx_state_d = RX_DATA;
                        end
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt + 1'b1;
                    if (rx_cnt == TICK_LAST) begin
                        rx_shift_d = {rxd_sync, rx_shift[DATA_BITS-1:1]};
                        rx_bit_d   = rx_bit + 1'b1;
                        if (rx_bit == BIT_LAST) rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_cnt_d = rx_cnt + 1'b1;
                    if (rx_cnt == TICK_LAST) begin
                        if (rxd_sync) begin
                            rx_done    = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_ferr    = 1'b1;
                            rx_state_d = RX_WAIT;
                        end
                    end
                end
            end
            RX_WAIT: begin
                if (rxd_sync) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: loopback and bench-driven RX frames, scoreboard queue.
module tb_uart_transceiver;

    localparam int FREQ_HZ   = 100_000_000;
    localparam int BAUD      = 1_000_000;
    localparam int DIV_RAW   = FREQ_HZ / (BAUD * 16);
    localparam int DIV_TB    = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int BIT_CLK   = 16 * DIV_TB;
    localparam int FRAME_CLK = 10 * BIT_CLK;
    localparam int HALF_CLK  = BIT_CLK / 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       loopback = 1'b1;
    logic       bench_rxd = 1'b1;
    logic       uart_rxd;
    logic       uart_txd;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_ack = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_busy;

    int         n_compared = 0;
    int         n_mismatched = 0;
    logic [7:0] sb_q[$];
    int         busy_len;
    int         pulses;
    int         wait_n;
    logic       seen_low;

    assign uart_rxd = loopback ? uart_txd : bench_rxd;

    always #5 clk = ~clk;

    uart_transceiver #(.freq_hz(FREQ_HZ), .baud(BAUD)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_error (rx_error),
        .rx_ack   (rx_ack),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tx_write(input logic [7:0] data, input bit push);
        tx_data = data;
        tx_wr   = 1'b1;
        if (push) sb_q.push_back(data);
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic wait_tx_idle(input string tag);
        int n;
        n = 0;
        while (tx_busy && n < 2 * FRAME_CLK) begin
            @(negedge clk);
            n++;
        end
        check(tag, tx_busy, 0);
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] exp_byte;
        check({tag, "_avail"}, rx_avail, 1);
        check({tag, "_error"}, rx_error, 0);
        check({tag, "_sb_pending"}, sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
            exp_byte = sb_q.pop_front();
            check({tag, "_data"}, rx_data, exp_byte);
        end
    endtask

    task automatic drive_frame(input logic [7:0] data, input logic stop_bit);
        bench_rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bench_rxd = data[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        bench_rxd = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
        bench_rxd = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Samples txd mid-bit; optionally fires a second tx_wr after bit inject_at.
    task automatic check_tx_wave(input logic [7:0] data, input int inject_at, input logic [7:0] inject_data);
        int         n;
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        n = 0;
        while (uart_txd && n < 4 * BIT_CLK) begin
            @(negedge clk);
            n++;
        end
        check("txd_start_edge", uart_txd, 0);
        repeat (HALF_CLK) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("txd_bit%0d", i), uart_txd, frame[i]);
            if (i == inject_at) begin
                tx_write(inject_data, 1'b0);
                repeat (BIT_CLK - 1) @(negedge clk);
            end else if (i < 9) begin
                repeat (BIT_CLK) @(negedge clk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_avail", rx_avail, 0);
        check("rst_rx_error", rx_error, 0);
        check("rst_rx_data", rx_data, 8'h00);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Loopback 0x67 with tx_busy duration measurement
        tx_data = 8'h67;
        tx_wr   = 1'b1;
        sb_q.push_back(8'h67);
        @(negedge clk);
        tx_wr = 1'b0;
        busy_len = 0;
        while (tx_busy && busy_len < 2 * FRAME_CLK) begin
            busy_len++;
            @(negedge clk);
        end
        check("tx_busy_len", (busy_len >= FRAME_CLK - 2 && busy_len <= FRAME_CLK + 2) ? FRAME_CLK : busy_len,
              FRAME_CLK);
        check_rx("rx_67");
        ack_pulse();
        check("ack_clears_avail", rx_avail, 0);

        // Eight back-to-back 0x00 frames
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tx_write(8'h00, 1'b1);
            wait_n = 0;
            while (!rx_avail && wait_n < 2 * FRAME_CLK) begin
                @(negedge clk);
                wait_n++;
            end
            if (rx_avail) pulses++;
            check_rx($sformatf("b2b_%0d", k));
            ack_pulse();
            wait_tx_idle($sformatf("b2b_tx_idle_%0d", k));
        end
        check("b2b_pulses", pulses, 8);

        // Frame with stop bit forced low
        loopback = 1'b0;
        drive_frame(8'h5A, 1'b0);
        check("ferr_error", rx_error, 1);
        check("ferr_avail", rx_avail, 0);
        check("ferr_data_kept", rx_data, 8'h00);
        ack_pulse();
        check("ferr_ack_clears", rx_error, 0);

        // Start-bit glitch of three ticks, then a good frame to prove re-arm
        bench_rxd = 1'b0;
        repeat (3 * DIV_TB) @(negedge clk);
        bench_rxd = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("glitch_avail", rx_avail, 0);
        check("glitch_error", rx_error, 0);
        sb_q.push_back(8'hC3);
        drive_frame(8'hC3, 1'b1);
        check_rx("rx_after_glitch");
        ack_pulse();

        // 0xA5 with a 0x3C write mid-frame that must be ignored
        loopback = 1'b1;
        tx_write(8'hA5, 1'b1);
        check_tx_wave(8'hA5, 4, 8'h3C);
        wait_tx_idle("a5_tx_idle");
        check_rx("rx_a5");
        seen_low = 1'b0;
        repeat (2 * BIT_CLK) begin
            @(negedge clk);
            if (!uart_txd) seen_low = 1'b1;
        end
        check("no_queued_frame", seen_low, 0);
        check("no_queued_busy", tx_busy, 0);

        // Overrun: 0x00 arrives while 0xA5 is still unacknowledged
        tx_write(8'h00, 1'b1);
        wait_tx_idle("overrun_tx_idle");
        check_rx("rx_overrun");
        ack_pulse();

        // Asynchronous reset in the middle of a TX frame
        tx_write(8'h55, 1'b0);
        repeat (2 * BIT_CLK + HALF_CLK) @(negedge clk);
        check("pre_reset_txd_low", uart_txd, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_txd", uart_txd, 1);
        check("async_rst_busy", tx_busy, 0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        tx_write(8'h55, 1'b1);
        check_tx_wave(8'h55, -1, 8'h00);
        wait_tx_idle("post_rst_tx_idle");
        check_rx("rx_55");
        ack_pulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
